// File: rtl/dmem_responder_if.sv
// Load/store handshake between the execute stage (master) and the data-memory
// responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        err;

  modport master (output req_valid, req_we, addr, wdata, input rdata, done, stall, err);
  modport slave  (input req_valid, req_we, addr, wdata, output rdata, done, stall, err);
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accept, wait WAIT_CYCLES, access, one-cycle done.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects word-misaligned requests with err.
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 8
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem [2**ADDR_W];
  logic                accept, access, misalign;
  logic                addr_unused;

  // High address bits wrap into the array; low bits only matter to the misalign check.
  assign addr_unused = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = |bus.addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.req_valid;
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request latches need no reset: they are only consumed after a fresh acceptance.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Memory is never reset; gating with rst drops a store aborted on the access edge.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q) mem[addr_q] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = misalign ? RESP : WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = bus.req_we;
      addr_d  = bus.addr[ADDR_W+1:2];
      wdata_d = bus.wdata;
      err_d   = misalign;
    end
    if (state_q == RESP) err_d = 1'b0;
    if (access && !we_q) rdata_d = mem[addr_q];
  end

  always_comb begin
    bus.done  = (state_q == RESP);
    bus.stall = accept || (state_q == WAIT);
    bus.err   = err_q;
    bus.rdata = rdata_q;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_W      = 8;
  localparam int DEPTH       = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  dmem_responder_if bus ();

  dmem_responder #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem [int];
  logic [31:0] rdata_m;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
    return (a % 4) != 0;
`else
    return (a % 4) != 0 && 1'b0;
`endif
  endfunction

  // One request. b2b: issue while the previous done is showing (req_valid held).
  // hold: keep req_valid high after done so the next call can chain.
  task automatic run_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit b2b, input bit hold);
    bit          mis, seen;
    int          exp_lat, cyc, idx;
    logic [31:0] exp_rd;
    mis     = is_misaligned(a);
    exp_lat = mis ? 1 : WAIT_CYCLES + 2;
    idx     = word_idx(a);
    if (!mis) begin
      if (we) model_mem[idx] = wd;
      else    rdata_m = model_mem[idx];
    end
    exp_rd = rdata_m;
    if (!b2b) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.addr      = a;
    bus.wdata     = wd;
    if (b2b) @(negedge clk);
    #1;
    chk("stall_c0", bus.stall, 1'b1);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
        chk("latency", cyc, exp_lat);
        chk("err", bus.err, mis);
        chk("rdata", bus.rdata, exp_rd);
        chk("stall_done", bus.stall, 1'b0);
        if (!hold) bus.req_valid = 1'b0;
      end else begin
        chk("stall_wait", bus.stall, 1'b1);
        bus.req_we = 1'($urandom);
        bus.addr   = $urandom;
        bus.wdata  = $urandom;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_stall"}, bus.stall, 1'b0);
  endtask

  initial begin
    bit          next_b2b, b2b;
    logic [31:0] a;
    int          idx;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    rdata_m       = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Known contents for words 0..31 so every later load has a defined answer.
    for (int i = 0; i < 32; i++) run_op(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

    run_op(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    run_op(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    chk("load_0x10", bus.rdata, 32'hDEADBEEF);
    run_op(1'b1, 32'h14, 32'hCAFEF00D, 1'b0, 1'b0);
    chk("store_keeps_rdata", bus.rdata, 32'hDEADBEEF);

    run_op(1'b1, 32'h404, 32'hA5A55A5A, 1'b0, 1'b1);
    run_op(1'b0, 32'h004, 32'h0, 1'b1, 1'b0);
    chk("alias_0x004", bus.rdata, 32'hA5A55A5A);

    // Reset during cycle 2 of a store: the write must be dropped.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rdata_m = 32'd0;
    chk_reset_outputs("midop_reset");
    run_op(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

    run_op(1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 32'h12, 32'h11112222, 1'b0, 1'b0);
    run_op(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    next_b2b = 1'b0;
    for (int n = 0; n < 150; n++) begin
      b2b      = next_b2b;
      next_b2b = (n != 149) && ($urandom_range(0, 3) == 0);
      idx      = $urandom_range(0, 31);
      a        = ($urandom & 32'hFFFF_FC00) | 32'(idx * 4);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      run_op(1'($urandom), a, $urandom, b2b, next_b2b);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have one clock and SHALL use a synchronous, active-high reset.
REQ-002 Parameter WAIT_CYCLES, 2, number of wait cycles inserted before each memory access (0..15).
REQ-003 Parameter ADDR_W, 8, word-index width; memory depth is 2**ADDR_W 32-bit words.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port req_valid  input  1  load/store request present; held by requester until done.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port addr  input  32  byte address from ALU result.
REQ-009 Port wdata  input  32  store data (register B operand from the execute stage).
REQ-010 Port rdata  output  32  registered load data.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port stall  output  1  combinational pipeline hold request.
REQ-013 Port err  output  1  misaligned-access flag, valid with done.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP, plus a 4-bit down-counter cnt.
REQ-015 IDLE with req_valid=1 (acceptance cycle, cycle 0) SHALL latch req_we, addr and wdata, load cnt with WAIT_CYCLES and go to WAIT.
REQ-016 In WAIT with cnt!=0, the block SHALL decrement cnt each cycle.
REQ-017 In WAIT with cnt==0, at the clock edge the block SHALL perform the access and go to RESP.
REQ-018 The access SHALL write mem[addr[ADDR_W+1:2]] with the latched wdata for a store, or load rdata from that location for a load.
REQ-019 RESP SHALL assert done for exactly one cycle (cycle WAIT_CYCLES+2) and return to IDLE; req_valid SHALL be ignored while in RESP.
REQ-020 stall SHALL equal (IDLE and req_valid) or WAIT, and SHALL be low in RESP.
REQ-021 A request held high across done SHALL be accepted in the following IDLE cycle, giving a back-to-back period of WAIT_CYCLES+3 cycles.
REQ-022 Address bits above ADDR_W+1 SHALL be ignored, wrapping the address into the memory.
REQ-023 Address bits [1:0] SHALL be handled as defined under Configuration.
REQ-024 rdata SHALL hold its last value until the next completed load.
REQ-025 A store SHALL leave rdata unchanged.
REQ-026 Inputs changing after acceptance SHALL NOT affect the in-flight access.
REQ-027 WAIT_CYCLES=0 SHALL give one WAIT cycle, with done in cycle 2.

Reset
REQ-028 While rst=1 the block SHALL set state=IDLE, cnt=0, rdata=0, done=0 and err=0; stall then follows REQ-020.
REQ-029 Reset mid-operation SHALL abort the access, so a pending store SHALL NOT be written.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 With macro DMEM_MISALIGN_CHECK_EN defined, acceptance with addr[1:0]!=0 SHALL skip WAIT and go straight to RESP.
REQ-032 That misaligned request SHALL make no memory access, SHALL pulse done with err=1 in cycle 1, and SHALL leave rdata unchanged.
REQ-033 Without DMEM_MISALIGN_CHECK_EN, err SHALL be tied 0 and addr[1:0] SHALL be ignored.

Verification
REQ-034 Reset, then store wdata=0xDEADBEEF to addr=0x10 with WAIT_CYCLES=2 -> stall high in cycles 0..3, done pulse in cycle 4, err=0.
REQ-035 Load from addr=0x10 -> done in cycle 4 with rdata=0xDEADBEEF; rdata is unchanged by a following store.
REQ-036 Back-to-back store then load to addr 0x404 with ADDR_W=8 -> the load returns the stored value via alias 0x004; the second request is accepted in the cycle after the first done.
REQ-037 Assert rst in cycle 2 of a store of 0x12345678 to addr 0x20 -> a later load of 0x20 returns the old value; outputs are 0 after reset.
REQ-038 With DMEM_MISALIGN_CHECK_EN, load addr=0x13 -> done and err=1 in cycle 1, memory untouched; without the macro, the same request reads word 0x10 with err=0.
